// File: rtl/cnn_pkg.sv
// Shared fixed-point types, FC-layer FSM states and the Q8.8 saturation helper
// used by the LeNet layer engines.
package cnn_pkg;

   localparam int DATA_W = 16;
   localparam int FRAC_W = 8;
   localparam int ACC_W  = 40;

   typedef logic signed [DATA_W-1:0] word_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BIAS_RD,
      ST_X_RD,
      ST_W_RD,
      ST_MAC,
      ST_WR,
      ST_DONE
   } fc_state_t;

   // Drops the fractional bits (arithmetic shift, i.e. floor) then clamps to Q8.8.
   function automatic word_t sat_q88(input acc_t a);
      acc_t s;
      s = a >>> FRAC_W;
      if (s > 40'sh00_0000_7FFF) begin
         return 16'sh7FFF;
      end else if (s < -40'sh00_0000_8000) begin
         return 16'sh8000;
      end
      return word_t'(s);
   endfunction

endpackage

// File: rtl/fc_layer_if.sv
// Request/acknowledge memory port between the FC engine (master) and the
// shared single-port RAM (slave).
interface fc_layer_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/fc_layer_mac.sv
// Wide multiply-accumulate for one FC output: bias preload, signed MAC,
// Q8.8 saturation and optional ReLU on the result.
module fc_mac
   import cnn_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  clear,
   input  logic  en,
   input  logic  relu_en,
   input  word_t bias,
   input  word_t x,
   input  word_t w,
   output word_t result
);

   acc_t                     acc;
   logic signed [2*DATA_W-1:0] prod;
   word_t                    sat;

   always_comb begin
      prod = x * w;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clear) begin
         acc <= acc_t'(bias) <<< FRAC_W;
      end else if (en) begin
         acc <= acc + acc_t'(prod);
      end
   end

   always_comb begin
      sat    = sat_q88(acc);
      result = (relu_en && sat[DATA_W-1]) ? '0 : sat;
   end

endmodule

// File: rtl/fc_layer.sv
// Fully-connected layer engine: walks outputs j and inputs i, fetching bias,
// input and weight words over the shared RAM port and writing each result back.
module fc_layer
   import cnn_pkg::*;
#(
   parameter int N_IN   = 120,
   parameter int N_OUT  = 84,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              relu_en,
   input  logic [ADDR_W-1:0] in_base,
   input  logic [ADDR_W-1:0] w_base,
   input  logic [ADDR_W-1:0] b_base,
   input  logic [ADDR_W-1:0] out_base,
   output logic              busy,
   output logic              done,
   fc_layer_if.master        mem
);

   localparam int unsigned IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
   localparam int unsigned JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   fc_state_t         state, state_n;
   logic [IW-1:0]     i;
   logic [JW-1:0]     j;
   logic [ADDR_W-1:0] in_base_r;
   logic [ADDR_W-1:0] b_ptr, x_ptr, w_ptr, o_ptr;
   logic              relu_r;
   word_t             x_q, w_q, rd_word, result;
   logic              last_i, last_j;

   assign rd_word = word_t'(mem.mem_rdata[DATA_W-1:0]);
   assign last_i  = (i == IW'(N_IN - 1));
   assign last_j  = (j == JW'(N_OUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:    if (start)        state_n = ST_BIAS_RD;
         ST_BIAS_RD: if (mem.mem_ack)  state_n = ST_X_RD;
         ST_X_RD:    if (mem.mem_ack)  state_n = ST_W_RD;
         ST_W_RD:    if (mem.mem_ack)  state_n = ST_MAC;
         ST_MAC:     state_n = last_i ? ST_WR : ST_X_RD;
         ST_WR:      if (mem.mem_ack)  state_n = last_j ? ST_DONE : ST_BIAS_RD;
         ST_DONE:    state_n = ST_IDLE;
         default:    state_n = ST_IDLE;
      endcase
   end

   // Port outputs decode straight from registered state/pointers, so they hold
   // steady for the whole of a memory state and fall to zero as soon as reset hits.
   always_comb begin
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
      busy          = (state != ST_IDLE);
      done          = (state == ST_DONE);
      case (state)
         ST_BIAS_RD: begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = b_ptr;
         end
         ST_X_RD: begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = x_ptr;
         end
         ST_W_RD: begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = w_ptr;
         end
         ST_WR: begin
            mem.mem_req   = 1'b1;
            mem.mem_we    = 1'b1;
            mem.mem_addr  = o_ptr;
            mem.mem_wdata = DATA_W'(result);
         end
         default: ;
      endcase
   end

   // The weight pointer runs continuously across outputs, so w_base+j*N_IN+i
   // never needs a multiplier.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i         <= '0;
         j         <= '0;
         in_base_r <= '0;
         b_ptr     <= '0;
         x_ptr     <= '0;
         w_ptr     <= '0;
         o_ptr     <= '0;
         relu_r    <= 1'b0;
         x_q       <= '0;
         w_q       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  relu_r    <= relu_en;
                  in_base_r <= in_base;
                  b_ptr     <= b_base;
                  w_ptr     <= w_base;
                  o_ptr     <= out_base;
                  j         <= '0;
               end
            end
            ST_BIAS_RD: begin
               if (mem.mem_ack) begin
                  i     <= '0;
                  x_ptr <= in_base_r;
               end
            end
            ST_X_RD: if (mem.mem_ack) x_q <= rd_word;
            ST_W_RD: if (mem.mem_ack) w_q <= rd_word;
            ST_MAC: begin
               i     <= i + 1'b1;
               x_ptr <= x_ptr + 1'b1;
               w_ptr <= w_ptr + 1'b1;
            end
            ST_WR: begin
               if (mem.mem_ack) begin
                  j     <= j + 1'b1;
                  b_ptr <= b_ptr + 1'b1;
                  o_ptr <= o_ptr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   fc_mac u_mac (
      .clk     (clk),
      .rst     (rst),
      .clear   ((state == ST_BIAS_RD) && mem.mem_ack),
      .en      (state == ST_MAC),
      .relu_en (relu_r),
      .bias    (rd_word),
      .x       (x_q),
      .w       (w_q),
      .result  (result)
   );

endmodule

// File: tb/tb_fc_layer.sv
// Bench for fc_layer: three instances (2x1, 5x6, 120x84) on one shared RAM model
// with configurable ack latency, checked against an arithmetic reference.
module tb_fc_layer;
   import cnn_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        relu_en = 1'b0;
   logic [15:0] in_base = '0, w_base = '0, b_base = '0, out_base = '0;
   logic        start_v [3] = '{default: 1'b0};
   logic        busy_v  [3];
   logic        done_v  [3];

   fc_layer_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
   fc_layer_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();
   fc_layer_if #(.ADDR_W(16), .DATA_W(16)) bus2 ();

   fc_layer #(.N_IN(2), .N_OUT(1)) dut_s (
      .clk(clk), .rst(rst), .start(start_v[0]), .relu_en(relu_en),
      .in_base(in_base), .w_base(w_base), .b_base(b_base), .out_base(out_base),
      .busy(busy_v[0]), .done(done_v[0]), .mem(bus0)
   );
   fc_layer #(.N_IN(5), .N_OUT(6)) dut_m (
      .clk(clk), .rst(rst), .start(start_v[1]), .relu_en(relu_en),
      .in_base(in_base), .w_base(w_base), .b_base(b_base), .out_base(out_base),
      .busy(busy_v[1]), .done(done_v[1]), .mem(bus1)
   );
   fc_layer #(.N_IN(120), .N_OUT(84)) dut_l (
      .clk(clk), .rst(rst), .start(start_v[2]), .relu_en(relu_en),
      .in_base(in_base), .w_base(w_base), .b_base(b_base), .out_base(out_base),
      .busy(busy_v[2]), .done(done_v[2]), .mem(bus2)
   );

   logic        req_v [3], we_v [3];
   logic [15:0] addr_v [3], wdata_v [3];
   logic        ack_v [3] = '{default: 1'b0};
   logic [15:0] rdata_v [3] = '{default: 16'h0};

   assign req_v[0] = bus0.mem_req;  assign we_v[0] = bus0.mem_we;
   assign req_v[1] = bus1.mem_req;  assign we_v[1] = bus1.mem_we;
   assign req_v[2] = bus2.mem_req;  assign we_v[2] = bus2.mem_we;
   assign addr_v[0] = bus0.mem_addr; assign wdata_v[0] = bus0.mem_wdata;
   assign addr_v[1] = bus1.mem_addr; assign wdata_v[1] = bus1.mem_wdata;
   assign addr_v[2] = bus2.mem_addr; assign wdata_v[2] = bus2.mem_wdata;
   assign bus0.mem_ack = ack_v[0];  assign bus0.mem_rdata = rdata_v[0];
   assign bus1.mem_ack = ack_v[1];  assign bus1.mem_rdata = rdata_v[1];
   assign bus2.mem_ack = ack_v[2];  assign bus2.mem_rdata = rdata_v[2];

   logic [15:0] ram [0:65535];
   bit          pend [3] = '{default: 1'b0};
   int          cnt [3];
   logic [15:0] s_addr [3], s_wdata [3];
   logic        s_we [3];
   int          wr_cnt [3] = '{default: 0};
   int          stab_err = 0;
   int          lat_mode = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   localparam logic [15:0] SENT = 16'hDEAD;

   function automatic int lat();
      case (lat_mode)
         0:       return 1;
         1:       return int'($urandom_range(1, 5));
         default: return ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 5)) : 1;
      endcase
   endfunction

   // RAM slave: ack is raised 'lat' cycles after a request is first seen and the
   // request fields are sampled every waiting cycle for stability.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            pend[k]  = 1'b0;
            ack_v[k] = 1'b0;
         end else begin
            if (ack_v[k]) begin
               ack_v[k] = 1'b0;
               pend[k]  = 1'b0;
            end
            if (req_v[k] && !pend[k]) begin
               pend[k]    = 1'b1;
               cnt[k]     = lat();
               s_addr[k]  = addr_v[k];
               s_we[k]    = we_v[k];
               s_wdata[k] = wdata_v[k];
            end else if (pend[k]) begin
               if (!req_v[k] || addr_v[k] !== s_addr[k] || we_v[k] !== s_we[k] ||
                   (s_we[k] && wdata_v[k] !== s_wdata[k]))
                  stab_err++;
               cnt[k] = cnt[k] - 1;
               if (cnt[k] == 0) begin
                  ack_v[k] = 1'b1;
                  if (s_we[k]) begin
                     ram[s_addr[k]] = s_wdata[k];
                     wr_cnt[k]++;
                  end else begin
                     rdata_v[k] = ram[s_addr[k]];
                  end
               end
            end
         end
      end
   end

   function automatic logic [15:0] ref_out(input int nin, input int j, input bit relu,
                                           input logic [15:0] ib, wb, bb);
      longint acc, s;
      acc = longint'($signed(ram[16'(bb + j)])) * 256;
      for (int i = 0; i < nin; i++)
         acc += longint'($signed(ram[16'(ib + i)])) * longint'($signed(ram[16'(wb + j * nin + i)]));
      s = acc >>> 8;
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      if (relu && s < 0) s = 0;
      return 16'(s);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic kick(input int k, input bit relu, input logic [15:0] ib, wb, bb, ob,
                       output bit busy0);
      @(negedge clk);
      relu_en = relu; in_base = ib; w_base = wb; b_base = bb; out_base = ob;
      start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;
      busy0 = busy_v[k];
   endtask

   task automatic wait_done(input int k, output int cyc);
      cyc = 0;
      while (!done_v[k] && cyc < 150000) begin
         @(negedge clk);
         cyc++;
      end
      check($sformatf("done_seen%0d", k), done_v[k], 1);
   endtask

   task automatic idle_check(input int k);
      int err;
      err = 0;
      @(negedge clk);
      check($sformatf("done_pulse%0d", k), done_v[k], 0);
      repeat (4) begin
         if (req_v[k] || busy_v[k]) err++;
         @(negedge clk);
      end
      check($sformatf("no_req_after_done%0d", k), err, 0);
   endtask

   task automatic check_outs(input string tag, input int nin, input int nout, input bit relu,
                             input logic [15:0] ib, wb, bb, ob);
      for (int j = 0; j < nout; j++)
         check($sformatf("%s[%0d]", tag, j), ram[16'(ob + j)], ref_out(nin, j, relu, ib, wb, bb));
   endtask

   task automatic fill(input logic [15:0] base, input int n, input int mode);
      for (int a = 0; a < n; a++) begin
         case (mode)
            0:       ram[16'(base + a)] = 16'($urandom);
            1:       ram[16'(base + a)] = 16'(int'($urandom_range(0, 1023)) - 512);
            default: ram[16'(base + a)] = 16'(int'($urandom_range(0, 127)) - 64);
         endcase
      end
   endtask

   task automatic small_case(input string tag, input bit relu, input logic [15:0] x0, x1,
                             input logic [15:0] w0, w1, b, exp);
      bit b0;
      int cyc;
      ram[16'h0010] = x0; ram[16'h0011] = x1;
      ram[16'h0020] = w0; ram[16'h0021] = w1;
      ram[16'h0030] = b;  ram[16'h0040] = SENT;
      kick(0, relu, 16'h0010, 16'h0020, 16'h0030, 16'h0040, b0);
      wait_done(0, cyc);
      check(tag, ram[16'h0040], exp);
      idle_check(0);
   endtask

   initial begin
      bit b0;
      int cyc, wc0, found;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", busy_v[2], 0);
      check("rst_done", done_v[2], 0);
      check("rst_req", bus2.mem_req, 0);
      check("rst_we", bus2.mem_we, 0);
      check("rst_addr", bus2.mem_addr, 0);
      check("rst_wdata", bus2.mem_wdata, 0);
      rst = 1'b0;

      // Basic 2x1 with 1-cycle ack and exact latency
      lat_mode = 0;
      ram[16'h0010] = 16'h0100; ram[16'h0011] = 16'h0200;
      ram[16'h0020] = 16'h0080; ram[16'h0021] = 16'h0100;
      ram[16'h0030] = 16'h0040; ram[16'h0040] = SENT;
      kick(0, 1'b0, 16'h0010, 16'h0020, 16'h0030, 16'h0040, b0);
      check("basic_busy_c0", b0, 1);
      wait_done(0, cyc);
      check("basic_done_cycle", cyc, 14);
      check("basic_out", ram[16'h0040], 16'h02C0);
      idle_check(0);

      // Saturation, ReLU and truncation corners
      small_case("sat_pos",    1'b0, 16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h7FFF, 16'h7FFF);
      small_case("sat_neg",    1'b0, 16'h7FFF, 16'h0, 16'h8000, 16'h0, 16'h0000, 16'h8000);
      small_case("sat_relu",   1'b1, 16'h7FFF, 16'h0, 16'h8000, 16'h0, 16'h0000, 16'h0000);
      small_case("trunc_pos",  1'b0, 16'h0001, 16'h0, 16'h0001, 16'h0, 16'h0000, 16'h0000);
      small_case("trunc_neg",  1'b0, 16'hFFFF, 16'h0, 16'h0001, 16'h0, 16'h0000, 16'hFFFF);
      check("stable_small", stab_err, 0);

      // 5x6 with random 1-5 cycle ack: reset during W_RD of output 3, then restart
      lat_mode = 1;
      fill(16'h0100, 5, 0);
      fill(16'h0200, 30, 0);
      fill(16'h0300, 6, 1);
      for (int j = 0; j < 6; j++) ram[16'(16'h0400 + j)] = SENT;
      wc0 = wr_cnt[1];
      kick(1, 1'b0, 16'h0100, 16'h0200, 16'h0300, 16'h0400, b0);
      found = 0;
      for (int n = 0; n < 5000 && found == 0; n++) begin
         @(negedge clk);
         if (req_v[1] && !we_v[1] && addr_v[1] >= 16'h020F && addr_v[1] < 16'h0214) found = 1;
      end
      check("found_wrd_out3", found, 1);
      rst = 1'b1;
      #1;
      check("rst_mid_req", bus1.mem_req, 0);
      check("rst_mid_busy", busy_v[1], 0);
      check("rst_mid_writes", wr_cnt[1] - wc0, 3);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_mid_no_more_writes", wr_cnt[1] - wc0, 3);
      check("rst_mid_out3_untouched", ram[16'h0403], SENT);
      check_outs("pre_rst", 5, 3, 1'b0, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
      for (int j = 0; j < 6; j++) ram[16'(16'h0400 + j)] = SENT;
      kick(1, 1'b0, 16'h0100, 16'h0200, 16'h0300, 16'h0400, b0);
      wait_done(1, cyc);
      check_outs("restart", 5, 6, 1'b0, 16'h0100, 16'h0200, 16'h0300, 16'h0400);

      // start while busy is ignored; start the cycle after done is accepted
      ram[16'h0500] = SENT;
      kick(1, 1'b1, 16'h0100, 16'h0200, 16'h0300, 16'h0400, b0);
      repeat (10) @(negedge clk);
      out_base = 16'h0500; in_base = 16'h0600; relu_en = 1'b0;
      start_v[1] = 1'b1;
      @(negedge clk);
      start_v[1] = 1'b0;
      wait_done(1, cyc);
      check_outs("relu_run", 5, 6, 1'b1, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
      check("busy_start_ignored", ram[16'h0500], SENT);
      fill(16'h0600, 5, 1);
      fill(16'h0700, 30, 1);
      fill(16'h0800, 6, 0);
      kick(1, 1'b0, 16'h0600, 16'h0700, 16'h0800, 16'h0900, b0);
      check("b2b_busy", b0, 1);
      wait_done(1, cyc);
      check_outs("b2b", 5, 6, 1'b0, 16'h0600, 16'h0700, 16'h0800, 16'h0900);
      idle_check(1);
      check("stable_mid", stab_err, 0);

      // Full 120x84 with occasional wait states
      lat_mode = 2;
      fill(16'h1000, 120, 1);
      fill(16'h2000, 120 * 84, 2);
      fill(16'h5000, 84, 0);
      kick(2, 1'b1, 16'h1000, 16'h2000, 16'h5000, 16'h5100, b0);
      wait_done(2, cyc);
      check_outs("full", 120, 84, 1'b1, 16'h1000, 16'h2000, 16'h5000, 16'h5100);
      idle_check(2);
      check("stable_full", stab_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
